// File: rtl/const_mon_pkg.sv
// const_mon_pkg: shared definitions for the constant tie-off monitor.
// Contents: FSM state encoding, expected line values, counter-width helper.
package const_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARM   = 2'b01,
    CHECK = 2'b10,
    FAULT = 2'b11
  } state_e;

  localparam logic ONE_EXP  = 1'b1;
  localparam logic ZERO_EXP = 1'b0;

  // Ceiling log2; callers pass (max_value + 1) to size a counter.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/const_sync.sv
// const_sync: STAGES-deep flop chain bringing an asynchronous level into clk.
// Ports:
//   clk   - block clock
//   reset - asynchronous, active-high reset (chain loads RESET_VAL)
//   d     - asynchronous input level
//   q     - synchronized level
// RESET_VAL is chosen equal to the line's expected value so that reset
// never produces a spurious mismatch.
module const_sync
  import const_mon_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/const_tie_monitor.sv
// const_tie_monitor: checks the buffered constant tie-off pair (one/zero)
// feeding the 1.8V I/O-cell controls, debounces mismatches and raises a
// sticky fault with per-line cause flags and a saturating fault counter.
//
// Ports:
//   clk         - block clock
//   reset       - asynchronous, active-high reset
//   enable      - monitor enable (synchronous)
//   one_in      - constant-high line under test (asynchronous)
//   zero_in     - constant-low line under test (asynchronous)
//   clear       - single-cycle pulse clearing sticky flags and fault_count
//   fault       - sticky fault flag
//   fault_one   - sticky: one line was low at fault entry
//   fault_zero  - sticky: zero line was high at fault entry
//   fault_count - number of fault entries, saturating
//   state       - current FSM state (debug)
//   irq         - single-cycle pulse on each CHECK->FAULT transition
//                 (present only when CONST_TIE_MON_IRQ_EN is defined)
//
// State table:
//   IDLE  (00) | monitor disabled
//   ARM   (01) | flushing stale synchronizer contents after enable
//   CHECK (10) | comparing samples, counting consecutive mismatches
//   FAULT (11) | fault latched, waiting for clear or disable
module const_tie_monitor
  import const_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             one_in,
  input  logic             zero_in,
  input  logic             clear,
  output logic             fault,
  output logic             fault_one,
  output logic             fault_zero,
  output logic [CNT_W-1:0] fault_count,
  output logic [1:0]       state
`ifdef CONST_TIE_MON_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int ARM_W = clog2(SYNC_STAGES + 1);
  localparam int DEB_W = clog2(DEBOUNCE + 1);

  logic             one_s;
  logic             zero_s;
  logic             mismatch;
  state_e           st;
  logic [ARM_W-1:0] arm_cnt;
  logic [DEB_W-1:0] deb_cnt;

  const_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(ONE_EXP)) u_sync_one (
    .clk   (clk),
    .reset (reset),
    .d     (one_in),
    .q     (one_s)
  );

  const_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(ZERO_EXP)) u_sync_zero (
    .clk   (clk),
    .reset (reset),
    .d     (zero_in),
    .q     (zero_s)
  );

  assign mismatch = (one_s != ONE_EXP) | (zero_s != ZERO_EXP);
  assign state    = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      arm_cnt     <= '0;
      deb_cnt     <= '0;
      fault       <= 1'b0;
      fault_one   <= 1'b0;
      fault_zero  <= 1'b0;
      fault_count <= '0;
`ifdef CONST_TIE_MON_IRQ_EN
      irq         <= 1'b0;
`endif
    end else begin
`ifdef CONST_TIE_MON_IRQ_EN
      irq <= 1'b0;
`endif
      if (clear) begin
        fault       <= 1'b0;
        fault_one   <= 1'b0;
        fault_zero  <= 1'b0;
        fault_count <= '0;
      end

      if (!enable) begin
        st      <= IDLE;
        deb_cnt <= '0;
      end else begin
        case (st)
          IDLE: begin
            st      <= ARM;
            arm_cnt <= ARM_W'(SYNC_STAGES);
          end
          ARM: begin
            arm_cnt <= arm_cnt - ARM_W'(1);
            if (arm_cnt == ARM_W'(1)) st <= CHECK;
          end
          CHECK: begin
            if (mismatch) begin
              if (deb_cnt == DEB_W'(DEBOUNCE - 1)) begin
                deb_cnt <= '0;
                // A clear landing on the entry edge cancels the entry entirely.
                if (!clear) begin
                  st         <= FAULT;
                  fault      <= 1'b1;
                  fault_one  <= fault_one | (one_s != ONE_EXP);
                  fault_zero <= fault_zero | (zero_s != ZERO_EXP);
                  if (fault_count != {CNT_W{1'b1}}) begin
                    fault_count <= fault_count + CNT_W'(1);
                  end
`ifdef CONST_TIE_MON_IRQ_EN
                  irq <= 1'b1;
`endif
                end
              end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
              end
            end else begin
              deb_cnt <= '0;
            end
          end
          FAULT: begin
            if (clear) begin
              st      <= CHECK;
              deb_cnt <= '0;
            end
          end
          default: begin
            st      <= IDLE;
            deb_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_const_tie_monitor.sv
// Bench for const_tie_monitor: directed scenarios plus randomized mismatch
// pulses, every cycle compared against a behavioural model built on
// "samples seen S edges late" and "edges spent enabled".
module tb_const_tie_monitor;

  localparam int S   = 2;
  localparam int DEB = 4;
  localparam int CW  = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          one_in;
  logic          zero_in;
  logic          clear;
  logic          fault;
  logic          fault_one;
  logic          fault_zero;
  logic [CW-1:0] fault_count;
  logic [1:0]    state;
`ifdef CONST_TIE_MON_IRQ_EN
  logic          irq;
  bit            m_irq;
`endif

  const_tie_monitor #(.SYNC_STAGES(S), .DEBOUNCE(DEB), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .one_in      (one_in),
    .zero_in     (zero_in),
    .clear       (clear),
    .fault       (fault),
    .fault_one   (fault_one),
    .fault_zero  (fault_zero),
    .fault_count (fault_count),
    .state       (state)
`ifdef CONST_TIE_MON_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // model: raw input history, enabled-edge age, mismatch run, outcomes
  bit oq[$];
  bit zq[$];
  int m_age;
  int m_run;
  bit m_faulted;
  bit m_fone;
  bit m_fzero;
  int m_cnt;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    oq.delete();
    zq.delete();
    for (int i = 0; i < S; i++) begin
      oq.push_back(1'b1);
      zq.push_back(1'b0);
    end
    m_age = 0;
    m_run = 0;
    m_faulted = 0;
    m_fone = 0;
    m_fzero = 0;
    m_cnt = 0;
`ifdef CONST_TIE_MON_IRQ_EN
    m_irq = 0;
`endif
  endtask

  // Applies one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit os, zs, mm, entered;
    os = oq[0];
    zs = zq[0];
    mm = !os || zs;
    entered = 0;
    if (clear) begin
      m_fone = 0;
      m_fzero = 0;
      m_cnt = 0;
    end
    if (!enable) begin
      m_age = 0;
      m_run = 0;
      m_faulted = 0;
    end else if (m_age <= S) begin
      m_age++;
    end else if (m_faulted) begin
      if (clear) begin
        m_faulted = 0;
        m_run = 0;
      end
    end else if (mm) begin
      m_run++;
      if (m_run == DEB) begin
        m_run = 0;
        entered = !clear;
      end
    end else begin
      m_run = 0;
    end
    if (entered) begin
      m_faulted = 1;
      m_fone  = m_fone | !os;
      m_fzero = m_fzero | zs;
      if (m_cnt < CMAX) m_cnt++;
    end
`ifdef CONST_TIE_MON_IRQ_EN
    m_irq = entered;
`endif
    void'(oq.pop_front());
    void'(zq.pop_front());
    oq.push_back(one_in);
    zq.push_back(zero_in);
  endtask

  // fault itself is sticky independently of the FSM: it follows the flags/clear
  bit m_fault = 0;

  task automatic check_all(input string tag);
    int es;
    es = m_faulted ? 3 : (m_age == 0 ? 0 : (m_age <= S ? 1 : 2));
    check({tag, ".state"}, int'(state), es);
    check({tag, ".fault"}, int'(fault), int'(m_fault));
    check({tag, ".fault_one"}, int'(fault_one), int'(m_fone));
    check({tag, ".fault_zero"}, int'(fault_zero), int'(m_fzero));
    check({tag, ".count"}, int'(fault_count), m_cnt);
`ifdef CONST_TIE_MON_IRQ_EN
    check({tag, ".irq"}, int'(irq), int'(m_irq));
`endif
  endtask

  task automatic tick(input string tag);
    bit was_faulted;
    int old_cnt;
    was_faulted = m_faulted;
    old_cnt = m_cnt;
    model_edge();
    if (clear) m_fault = 0;
    if (m_faulted && !was_faulted) m_fault = 1;
    if (m_cnt != old_cnt && m_cnt != 0) m_fault = 1;
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    one_in = 1'b1;
    zero_in = 1'b0;
    clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // arm and idle-check
    enable = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick("idle");
      if (i == 2) check("arm2.state", int'(state), 1);
      if (i == 3) check("arm3.state", int'(state), 2);
    end

    // persistent one_in low: fault exactly 6 edges later
    one_in = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick("lat_one");
      if (i == 5) check("lat5.fault", int'(fault), 0);
    end
    check("lat6.fault", int'(fault), 1);
    check("lat6.fault_one", int'(fault_one), 1);
    check("lat6.fault_zero", int'(fault_zero), 0);
    check("lat6.count", int'(fault_count), 1);
    check("lat6.state", int'(state), 3);
    one_in = 1'b1;
    clear = 1'b1;
    tick("clr1");
    clear = 1'b0;
    repeat (6) tick("settle");

    // zero_in pulses of 3 (tolerated) and 4 (fault)
    zero_in = 1'b1;
    repeat (3) tick("zp3");
    zero_in = 1'b0;
    repeat (6) tick("zp3q");
    check("zp3.fault", int'(fault), 0);
    zero_in = 1'b1;
    repeat (4) tick("zp4");
    zero_in = 1'b0;
    repeat (6) tick("zp4q");
    check("zp4.fault", int'(fault), 1);
    check("zp4.fault_zero", int'(fault_zero), 1);
    check("zp4.fault_one", int'(fault_one), 0);

    // held mismatch, clear, re-fault 4 edges after clear
    zero_in = 1'b1;
    repeat (8) tick("hold");
    clear = 1'b1;
    tick("clr2");
    clear = 1'b0;
    check("clr2.count", int'(fault_count), 0);
    for (int i = 1; i <= 4; i++) begin
      tick("refault");
      if (i == 3) check("refault3.fault", int'(fault), 0);
    end
    check("refault4.fault", int'(fault), 1);
    check("refault4.count", int'(fault_count), 1);

    // clear on the exact entry edge
    clear = 1'b1;
    tick("clr3");
    clear = 1'b0;
    repeat (3) tick("pre_entry");
    clear = 1'b1;
    tick("entry_clr");
    clear = 1'b0;
    check("entry_clr.fault", int'(fault), 0);
    check("entry_clr.count", int'(fault_count), 0);
    check("entry_clr.state", int'(state), 2);
    zero_in = 1'b0;
    enable = 1'b0;
    tick("dis");
    enable = 1'b1;
    repeat (6) tick("rearm");

    // randomized pulses on either line with sporadic clear/disable
    for (int k = 0; k < 60; k++) begin
      int len, gap;
      bit line;
      line = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      gap = int'($urandom_range(1, 8));
      if (line) one_in = 1'b0; else zero_in = 1'b1;
      for (int j = 0; j < len + gap; j++) begin
        if (j == len) begin
          one_in = 1'b1;
          zero_in = 1'b0;
        end
        clear = ($urandom_range(0, 11) == 0);
        enable = ($urandom_range(0, 29) != 0);
        tick("rnd");
      end
      clear = 1'b0;
      enable = 1'b1;
    end
    repeat (6) tick("rnd_end");

    // saturation: 300 five-cycle mismatch runs, FAULT left via enable
    for (int k = 0; k < 300; k++) begin
      one_in = 1'b0;
      repeat (5) tick("sat");
      one_in = 1'b1;
      repeat (2) tick("sat");
      enable = 1'b0;
      tick("sat_dis");
      enable = 1'b1;
      repeat (3) tick("sat_arm");
    end
    check("sat.count", int'(fault_count), CMAX);

    // asynchronous reset in the middle of debouncing
    one_in = 1'b0;
    repeat (4) tick("mid_deb");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    m_fault = 0;
    check("arst.fault", int'(fault), 0);
    check("arst.fault_one", int'(fault_one), 0);
    check("arst.fault_zero", int'(fault_zero), 0);
    check("arst.count", int'(fault_count), 0);
    check("arst.state", int'(state), 0);
    @(negedge clk);
    check_all("arst_hold");
    one_in = 1'b1;
    reset = 1'b0;
    repeat (10) tick("post_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/const_tie_monitor.md
Name: const_tie_monitor

Overview:
- Consumer-side checker for the buffered constant tie-off pair (one/zero) that feeds I/O-cell control inputs in the 1.8V domain.
- Synchronizes both lines and continuously compares them against their expected values (1/0).
- Debounces mismatches and raises a sticky fault with per-line cause flags and a saturating fault counter, for housekeeping readback.

Parameters:
- SYNC_STAGES, 2, synchronizer depth per monitored line (legal values 2..4).
- DEBOUNCE, 4, consecutive mismatched synchronized samples required to declare a fault (legal values 1..15).
- CNT_W, 8, width of fault_count.

Ports:
- clk  input  1  block clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  monitor enable (synchronous to clk).
- one_in  input  1  constant-high line under test (asynchronous to clk).
- zero_in  input  1  constant-low line under test (asynchronous to clk).
- clear  input  1  single-cycle pulse; clears sticky flags and fault_count.
- fault  output  1  sticky fault flag.
- fault_one  output  1  sticky flag: one_in was low at fault entry.
- fault_zero  output  1  sticky flag: zero_in was high at fault entry.
- fault_count  output  CNT_W  number of fault entries, saturating.
- state  output  2  current FSM state (debug).

Behaviour:
- Interface (decided): one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values:
  - Outputs: fault=0, fault_one=0, fault_zero=0, fault_count=0, state=IDLE (2'b00).
  - one-line synchronizer flops reset to 1; zero-line synchronizer flops reset to 0. No spurious mismatch after reset.
  - Debounce counter resets to 0.
- Synchronized samples are one_s and zero_s. mismatch = ~one_s | zero_s.
- FSM states:
  - IDLE (00): enable=1 -> ARM; arm counter loaded with SYNC_STAGES.
  - ARM (01): arm counter decrements each cycle; at 0 -> CHECK. Flushes stale synchronizer contents.
  - CHECK (10):
    - mismatch -> debounce counter increments.
    - Good sample -> debounce counter returns to 0.
    - When the DEBOUNCE-th consecutive mismatch is evaluated -> FAULT, on that same edge: fault=1, fault_one|=~one_s, fault_zero|=zero_s, fault_count increments.
  - FAULT (11): holds until clear; clear -> CHECK with debounce counter 0. A persisting mismatch re-faults after DEBOUNCE more cycles.
- Latency: a persistent input mismatch arriving while in CHECK asserts fault SYNC_STAGES+DEBOUNCE rising edges after the input changes.
- Any state with enable=0 -> IDLE next cycle; debounce counter zeroed; sticky flags and fault_count retained.
- clear, any state: fault, fault_one, fault_zero and fault_count go to 0 next edge.
- Simultaneous clear and the fault-entry edge: clear wins. No flag set, no count increment, next state CHECK with debounce counter 0.
- fault_count saturates at 2^CNT_W-1; it never wraps.
- Asynchronous reset mid-operation returns everything to the reset values immediately.

Optional Feature:
- Macro CONST_TIE_MON_IRQ_EN.
- Defined: adds output port irq (1 bit). irq is a single-cycle pulse, registered, on every CHECK->FAULT transition; reset value 0; suppressed when clear wins (see above).
- Undefined: no irq port and no irq logic; all other behaviour is identical.

Decomposition:
- Shared package const_mon_pkg holds:
  - state encodings IDLE/ARM/CHECK/FAULT (2-bit);
  - expected-value constants ONE_EXP=1, ZERO_EXP=0;
  - a counter-width helper function (clog2).
- One sub-module, const_sync: a SYNC_STAGES-deep flop chain with a parameterized RESET_VAL, instantiated twice (RESET_VAL=1 for one_in, 0 for zero_in).

Test Plan (SYNC_STAGES=2, DEBOUNCE=4, CNT_W=8):
- Reset, enable=1, one_in=1, zero_in=0 for 100 cycles -> state reaches CHECK after 3 edges; fault=0 throughout; fault_count=0.
- In CHECK, drive one_in=0 permanently at edge T -> fault=1 and fault_one=1 at edge T+6; fault_zero=0; fault_count=1; state=FAULT.
- In CHECK, pulse zero_in=1 for 3 cycles, then return to 0 -> no fault, counter returns to 0. Repeat with 4 cycles -> fault=1, fault_zero=1.
- Held mismatch, then clear pulse -> flags and count cleared. Fault re-asserts 4 edges after clear; fault_count=1.
- Drive clear on the exact fault-entry edge -> fault stays 0, fault_count unchanged, state=CHECK; with the macro defined, no irq pulse.
- Toggle a mismatch on/off 300 times, 5-cycle runs, clear never asserted between faults (leave FAULT via enable toggle) -> fault_count saturates at 255. Separately, assert reset mid-debounce -> all outputs return to reset values immediately.
